// File: rtl/monitor_cmd_pkg.sv
// Shared constants and state encoding for the monitor memory command engine.
//   CMD_WR / CMD_RD : opcode bytes accepted from the host
//   RSP_ACK/RSP_ERR : single-byte replies returned to the host
//   state_e         : command FSM states
package monitor_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WDATA,
    ST_WR,
    ST_ACK,
    ST_CNT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SEND,
    ST_ERR
  } state_e;

endpackage

// File: rtl/monitor_byte_timeout.sv
// Inter-byte timeout for partially received commands.
//   clk, reset : clock, asynchronous active-high reset
//   reload_i   : a byte was accepted; restart the count
//   enable_i   : the FSM is waiting for further bytes of a command
//   expire_o   : one-cycle pulse after TIMEOUT_CYCLES idle enabled cycles
// TIMEOUT_CYCLES = 0 removes the counter entirely.
module monitor_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload_i,
  input  logic enable_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = ^{clk, reset, reload_i, enable_i};
      assign expire_o  = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;

      // Count saturates at zero so a stale expiry cannot repeat.
      always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
          cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires on the TIMEOUT_CYCLES-th enabled cycle without a byte.
      assign expire_o = enable_i && !reload_i && (cnt_q == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/monitor_mem_cmd_master.sv
// Byte-stream command engine for the monitor on-chip memory.
// Host commands (big-endian):
//   'W' AH AL D3 D2 D1 D0 -> write one word, reply 'K'
//   'R' AH AL N           -> read N words (0 = 256), reply 4*N bytes MSB first
//   other                 -> reply '?'
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready         : command byte stream from UART RX
//   out_data/out_valid/out_ready      : response byte stream to UART TX
//   avm_*                             : Avalon-MM master to memory s1 (1-cycle read latency)
//   busy                              : command in progress
module monitor_mem_cmd_master
  import monitor_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              avm_clken,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       shift_q, shift_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              clken_q;

  logic take;
  logic cmd_phase;
  logic expire;

  // Held low during reset so every output except clken reads 0.
  assign in_ready  = !reset && (state_q inside {ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA, ST_CNT});
  assign take      = in_valid && in_ready;
  assign cmd_phase = state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_WDATA, ST_CNT};

  monitor_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .reload_i (take),
    .enable_i (cmd_phase),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: if (take) begin
        if (in_data == CMD_WR) begin
          is_wr_d = 1'b1;
          state_d = ST_ADDR_HI;
        end else if (in_data == CMD_RD) begin
          is_wr_d = 1'b0;
          state_d = ST_ADDR_HI;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_ADDR_HI: if (take) begin
        hi_d    = in_data;
        state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (take) begin
        // Upper address-byte bits beyond ADDR_W are dropped here.
        addr_d  = ADDR_W'({hi_q, in_data});
        idx_d   = 2'd0;
        state_d = is_wr_q ? ST_WDATA : ST_CNT;
      end
      ST_WDATA: if (take) begin
        wdata_d = {wdata_q[23:0], in_data};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_WR;
      end
      ST_WR:   state_d = ST_ACK;
      ST_ACK:  if (out_ready) state_d = ST_IDLE;
      ST_CNT: if (take) begin
        cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
        state_d = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        shift_d = avm_readdata;
        idx_d   = 2'd0;
        state_d = ST_RD_SEND;
      end
      ST_RD_SEND: if (out_ready) begin
        shift_d = {shift_q[23:0], 8'h00};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? ST_IDLE : ST_RD_ISSUE;
        end
      end
      ST_ERR:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abandon a stalled partial command without touching memory.
    if (expire) state_d = ST_IDLE;
  end

  // Reply byte is derived from the next state so out_data is a register
  // that only moves when the FSM moves on.
  always_comb begin
    out_valid_d = state_d inside {ST_ACK, ST_ERR, ST_RD_SEND};
    out_data_d  = 8'h00;
    unique case (state_d)
      ST_ACK:     out_data_d = RSP_ACK;
      ST_ERR:     out_data_d = RSP_ERR;
      ST_RD_SEND: out_data_d = shift_d[31:24];
      default:    out_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      hi_q        <= 8'h00;
      addr_q      <= '0;
      cnt_q       <= 9'd0;
      idx_q       <= 2'd0;
      wdata_q     <= 32'h0;
      shift_q     <= 32'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      clken_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      clken_q     <= 1'b1;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign avm_chipselect = (state_q == ST_WR) || (state_q == ST_RD_ISSUE);
  assign avm_write      = (state_q == ST_WR);
  assign avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_clken      = clken_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_monitor_mem_cmd_master.sv
`timescale 1ns/1ps
module tb_monitor_mem_cmd_master;

  localparam int ADDR_W = 11;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_clken;
  logic              busy;

  always #5 clk = ~clk;

  monitor_mem_cmd_master #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken),
    .busy           (busy)
  );

  // Memory slave: single port, one-cycle registered read.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (avm_chipselect) begin
      if (avm_write) mem[avm_address] <= avm_writedata;
      else           avm_readdata     <= mem[avm_address];
    end
  end

  // Behavioural model: word memory plus queues of expected traffic.
  logic [31:0]       model_mem [int];
  logic [7:0]        exp_q [$];
  logic [ADDR_W+31:0] wq [$];
  logic [ADDR_W-1:0] rq [$];
  logic [7:0]        rx_log [$];
  logic [7:0]        lit [8];

  int n_chk = 0;
  int n_pass = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  int rx_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       last_wr_data = '0;
  logic              prev_stall = 1'b0;
  logic [7:0]        prev_data = 8'h00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (out_valid) begin
        if (prev_stall) chk("hold_out_data", 32'(out_data), 32'(prev_data));
        chk("in_ready_while_reply", 32'(in_ready), 32'd0);
        chk("no_mem_while_reply", 32'(avm_chipselect), 32'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("byte_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            chk("out_byte", 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          rx_log.push_back(out_data);
          rx_cnt <= rx_cnt + 1;
        end
      end
      if (avm_chipselect) begin
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        if (avm_write) begin
          wr_seen      <= wr_seen + 1;
          last_wr_addr <= avm_address;
          last_wr_data <= avm_writedata;
          if (wq.size() == 0) begin
            chk("write_expected", 32'(wq.size()), 32'd1);
          end else begin
            chk("wr_addr", 32'(avm_address), 32'(wq[0][ADDR_W+31:32]));
            chk("wr_data", avm_writedata, wq[0][31:0]);
            void'(wq.pop_front());
          end
        end else begin
          rd_seen <= rd_seen + 1;
          if (rq.size() == 0) begin
            chk("read_expected", 32'(rq.size()), 32'd1);
          end else begin
            chk("rd_addr", 32'(avm_address), 32'(rq[0]));
            void'(rq.pop_front());
          end
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cmd_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    logic [15:0] a16;
    a16 = 16'(a);
    $display("cmd W addr=%03h data=%08h", a, d);
    model_mem[int'(a)] = d;
    wq.push_back({a, d});
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic cmd_read(input logic [ADDR_W-1:0] a, input logic [7:0] n);
    logic [15:0] a16;
    logic [31:0] w;
    int words;
    a16   = 16'(a);
    words = (n == 8'h00) ? 256 : int'(n);
    $display("cmd R addr=%03h n=%0d", a, words);
    for (int i = 0; i < words; i++) begin
      w = model_mem[(int'(a) + i) % 2048];
      rq.push_back(ADDR_W'((int'(a) + i) % 2048));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    send_byte(8'h52);
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    send_byte(n);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0 || rq.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("done_wait", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("idle_after_cmd", 32'(busy), 32'd0);
  endtask

  task automatic wait_rx(input int tgt);
    int n;
    n = 0;
    while (rx_cnt < tgt && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) chk("rx_wait", 32'(rx_cnt), 32'(tgt));
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int base, rd0, wr0, rx0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_clken", 32'(avm_clken), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1. Single write
    cmd_write(11'h123, 32'hDEADBEEF);
    wait_done();
    chk("t1_writes", 32'(wr_seen), 32'd1);
    chk("t1_addr_lit", 32'(last_wr_addr), 32'h123);
    chk("t1_data_lit", last_wr_data, 32'hDEADBEEF);
    chk("t1_ack_lit", 32'(rx_log[rx_log.size()-1]), 32'h4B);

    // 2. Single-word read
    rd0  = rd_seen;
    base = rx_log.size();
    cmd_read(11'h123, 8'h01);
    wait_done();
    chk("t2_reads", 32'(rd_seen - rd0), 32'd1);
    lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk("t2_byte_lit", 32'(rx_log[base+i]), 32'(lit[i]));

    // 3. Read across the address wrap
    cmd_write(11'h7FF, 32'h11223344);
    wait_done();
    cmd_write(11'h000, 32'h55667788);
    wait_done();
    rd0  = rd_seen;
    base = rx_log.size();
    cmd_read(11'h7FF, 8'h02);
    wait_done();
    chk("t3_reads", 32'(rd_seen - rd0), 32'd2);
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) chk("t3_byte_lit", 32'(rx_log[base+i]), 32'(lit[i]));

    // 4. Back-pressure mid-dump
    for (int i = 0; i < 4; i++) begin
      cmd_write(ADDR_W'(16 + i), 32'hA0B0C0D0 + 32'(i * 32'h01010101));
      wait_done();
    end
    base = rx_cnt;
    cmd_read(11'h010, 8'h04);
    wait_rx(base + 6);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rd0 = rd_seen;
    repeat (50) @(negedge clk);
    chk("t4_no_access", 32'(rd_seen), 32'(rd0));
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();

    // 5. Bad opcode, then a timed-out partial write
    exp_q.push_back(8'h3F);
    $display("cmd ? byte=41");
    send_byte(8'h41);
    wait_done();
    chk("t5_err_lit", 32'(rx_log[rx_log.size()-1]), 32'h3F);
    wr0 = wr_seen;
    rx0 = rx_cnt;
    $display("cmd W partial addr=005");
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h05);
    repeat (TMO - 10) @(negedge clk);
    chk("t5_still_waiting", 32'(busy), 32'd1);
    repeat (60) @(negedge clk);
    chk("t5_timeout_idle", 32'(busy), 32'd0);
    chk("t5_no_write", 32'(wr_seen), 32'(wr0));
    chk("t5_no_reply", 32'(rx_cnt), 32'(rx0));
    cmd_read(11'h123, 8'h01);
    wait_done();

    // 6. Reset during RD_SEND
    base = rx_cnt;
    cmd_read(11'h010, 8'h04);
    wait_rx(base + 5);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    wait_out_valid();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cs", 32'(avm_chipselect), 32'd0);
    chk("t6_rst_clken", 32'(avm_clken), 32'd1);
    exp_q.delete();
    rq.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd0  = rd_seen;
    base = rx_log.size();
    cmd_read(11'h000, 8'h01);
    wait_done();
    chk("t6_reads", 32'(rd_seen - rd0), 32'd1);
    lit = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) chk("t6_byte_lit", 32'(rx_log[base+i]), 32'(lit[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
